// File: rtl/ultra_pkg.sv
// Shared types and default constants for the ultrasonic ranger receive path.
package ultra_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    MEASURE,
    DONE
  } state_e;

  // Width of the distance output in centimetres.
  localparam int unsigned DIST_W = 10;

  // Default timing constants for a 100 MHz CLKOUT1.
  localparam int unsigned DEF_CLK_PER_US   = 100;
  localparam int unsigned DEF_US_PER_CM    = 58;
  localparam int unsigned DEF_WAIT_RISE_US = 5000;
  localparam int unsigned DEF_MAX_ECHO_US  = 30000;

endpackage

// File: rtl/echo_sync.sv
// ECHO input conditioning: 2-flop synchronizer, optional glitch filter and
// edge detection. Define ECHO_GLITCH_FILTER_EN to enable the filter.
module echo_sync
  import ultra_pkg::*;
#(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic echo_i,
  output logic echo_s_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic lvl;

  // Two-stage synchronizer for the asynchronous ECHO line.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= echo_i;
      sync_q <= meta_q;
    end
  end

`ifdef ECHO_GLITCH_FILTER_EN
  logic [FILT_LEN-1:0] hist_q;
  logic                filt_q;

  // Level only follows the input once FILT_LEN consecutive samples agree.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q <= '0;
      filt_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[FILT_LEN-2:0], sync_q};
      if (&hist_q) begin
        filt_q <= 1'b1;
      end else if (~|hist_q) begin
        filt_q <= 1'b0;
      end
    end
  end

  assign lvl = filt_q;
`else
  // Filter depth has no meaning when the raw synchronized level is used.
  logic [31:0] unused_filt_len;
  assign unused_filt_len = FILT_LEN;

  assign lvl = sync_q;
`endif

  // Previous conditioned level for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= lvl;
    end
  end

  assign echo_s_o = lvl;
  assign rise_o   = lvl & ~prev_q;
  assign fall_o   = ~lvl & prev_q;

endmodule

// File: rtl/echo_meter.sv
// Ultrasonic ranger receive side: arms on a start rising edge, times the ECHO
// pulse in microseconds and derives the distance in centimetres without a
// divider. Define ECHO_GLITCH_FILTER_EN to filter short ECHO glitches.
module echo_meter
  import ultra_pkg::*;
#(
  parameter int unsigned CLK_PER_US   = DEF_CLK_PER_US,
  parameter int unsigned WIDTH_US     = 16,
  parameter int unsigned WAIT_RISE_US = DEF_WAIT_RISE_US,
  parameter int unsigned MAX_ECHO_US  = DEF_MAX_ECHO_US,
  parameter int unsigned US_PER_CM    = DEF_US_PER_CM,
  parameter int unsigned FILT_LEN     = 4
) (
  input  logic                CLKOUT1,
  input  logic                reset,
  input  logic                start,
  input  logic                ECHO,
  output logic [WIDTH_US-1:0] echo_us,
  output logic [DIST_W-1:0]   dist_cm,
  output logic                valid,
  output logic                timeout,
  output logic                busy
);

  localparam int unsigned PresW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int unsigned SubW  = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;

  localparam logic [PresW-1:0]    PresLast = PresW'(CLK_PER_US - 1);
  localparam logic [SubW-1:0]     SubLast  = SubW'(US_PER_CM - 1);
  localparam logic [WIDTH_US-1:0] WaitLim  = WIDTH_US'(WAIT_RISE_US);
  localparam logic [WIDTH_US-1:0] MaxLim   = WIDTH_US'(MAX_ECHO_US);

  state_e              state_q;
  logic [PresW-1:0]    presc_q;
  logic [WIDTH_US-1:0] us_cnt_q;
  logic [SubW-1:0]     cm_sub_q;
  logic [DIST_W-1:0]   cm_cnt_q;
  logic                to_q;
  logic                start_q;
  logic                start_prev_q;
  logic [WIDTH_US-1:0] echo_us_q;
  logic [DIST_W-1:0]   dist_cm_q;
  logic                valid_q;
  logic                timeout_q;

  logic echo_s;
  logic echo_rise;
  logic echo_fall;
  logic start_rise;
  logic us_tick;
  logic presc_clr;

  echo_sync #(
    .FILT_LEN(FILT_LEN)
  ) u_sync (
    .clk_i   (CLKOUT1),
    .rst_ni  (reset),
    .echo_i  (ECHO),
    .echo_s_o(echo_s),
    .rise_o  (echo_rise),
    .fall_o  (echo_fall)
  );

  // Register the trigger line so its rising edge can be detected.
  always_ff @(posedge CLKOUT1 or negedge reset) begin
    if (!reset) begin
      start_q      <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      start_q      <= start;
      start_prev_q <= start_q;
    end
  end

  assign start_rise = start_q & ~start_prev_q;
  assign us_tick    = (presc_q == PresLast);

  // Prescaler restarts whenever a timed phase begins so each phase gets whole microseconds.
  always_comb begin
    presc_clr = 1'b0;
    if ((state_q == IDLE) && start_rise) begin
      presc_clr = 1'b1;
    end else if ((state_q == WAIT_RISE) && echo_rise) begin
      presc_clr = 1'b1;
    end
  end

  // Microsecond prescaler.
  always_ff @(posedge CLKOUT1 or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
    end else if (presc_clr || us_tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  // Measurement FSM with its counters and registered outputs.
  always_ff @(posedge CLKOUT1 or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      us_cnt_q  <= '0;
      cm_sub_q  <= '0;
      cm_cnt_q  <= '0;
      to_q      <= 1'b0;
      echo_us_q <= '0;
      dist_cm_q <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_rise) begin
            state_q  <= WAIT_RISE;
            us_cnt_q <= '0;
            cm_sub_q <= '0;
            cm_cnt_q <= '0;
            to_q     <= 1'b0;
          end
        end
        WAIT_RISE: begin
          if (echo_rise) begin
            state_q  <= MEASURE;
            us_cnt_q <= '0;
          end else if (us_cnt_q == WaitLim) begin
            state_q  <= DONE;
            to_q     <= 1'b1;
            us_cnt_q <= '0;
          end else if (us_tick) begin
            us_cnt_q <= us_cnt_q + 1'b1;
          end
        end
        MEASURE: begin
          // A tick coinciding with the fall still counts, so a pulse of N whole
          // microseconds reports N; the count never passes the ceiling.
          if (us_tick && (us_cnt_q != MaxLim)) begin
            us_cnt_q <= us_cnt_q + 1'b1;
            if (cm_sub_q == SubLast) begin
              cm_sub_q <= '0;
              cm_cnt_q <= cm_cnt_q + 1'b1;
            end else begin
              cm_sub_q <= cm_sub_q + 1'b1;
            end
          end
          if (echo_fall) begin
            state_q <= DONE;
            to_q    <= 1'b0;
          end else if (us_cnt_q == MaxLim) begin
            state_q <= DONE;
            to_q    <= 1'b1;
          end
        end
        DONE: begin
          echo_us_q <= us_cnt_q;
          dist_cm_q <= cm_cnt_q;
          timeout_q <= to_q;
          valid_q   <= 1'b1;
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign echo_us = echo_us_q;
  assign dist_cm = dist_cm_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;
  assign busy    = (state_q != IDLE);

endmodule
